// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, the NOP encoding and
// the fetch FSM state enumeration.
package cpu_pkg;

  localparam int unsigned XLEN_DEF      = 64;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    FAULT = 2'd3
  } if_state_e;

  // Instructions are 32-bit; anything not word aligned is a fetch fault.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_stage_if_id_reg.sv
// Fetch-to-decode output buffer: one entry, with load, clear and hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            fault_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o,
  output logic            id_fault_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            fault_q;

  // Clear empties the entry back to a NOP; load captures a new entry;
  // otherwise the entry holds while decode is stalled.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
      fault_q <= fault_i;
    end
  end

  assign id_valid_o = valid_q;
  assign id_pc_o    = pc_q;
  assign id_instr_o = instr_q;
  assign id_fault_o = fault_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues one outstanding memory request at a time,
// buffers the returned word for decode, and handles redirects and
// misaligned-PC faults.
//
// state | meaning
// IDLE  | ready to issue a request (or raise a fault) when the buffer is free
// WAIT  | request granted, waiting for the response
// DROP  | redirected while waiting; the stale response must be swallowed
// FAULT | misaligned PC reported to decode; parked until a redirect
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_en,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            id_fault
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic buf_free;
  logic misaligned;
  logic req_c;
  logic pc_en_c;
  logic load;
  logic load_fault;
  logic clear;

  assign buf_free   = !id_valid || id_ready;
  assign misaligned = addr_misaligned(pc_addr[1:0]);

  // Next-state and control decode; redirect overrides every state.
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    req_c      = 1'b0;
    pc_en_c    = 1'b0;
    load       = 1'b0;
    load_fault = 1'b0;
    clear      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!redirect && buf_free) begin
          if (!misaligned) begin
            req_c = 1'b1;
            if (imem_gnt) begin
              req_pc_d = pc_addr;
              state_d  = WAIT;
            end
          end else begin
            load       = 1'b1;
            load_fault = 1'b1;
            state_d    = FAULT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          if (!redirect) begin
            load    = 1'b1;
            pc_en_c = 1'b1;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      FAULT: begin
        if (redirect) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_en_c = 1'b1;
      req_c   = 1'b0;
      clear   = 1'b1;
    end
    if (id_valid && id_ready && !load) clear = 1'b1;
  end

  // State and captured request address; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req  = req_c && !reset;
  assign pc_en     = pc_en_c && !reset;
  assign imem_addr = pc_addr;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .clear_i    (clear),
    .pc_i       (load_fault ? pc_addr : req_pc_q),
    .instr_i    (load_fault ? NOP_INSTR : imem_rdata),
    .fault_i    (load_fault),
    .id_valid_o (id_valid),
    .id_pc_o    (id_pc),
    .id_instr_o (id_instr),
    .id_fault_o (id_fault)
  );

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a small PC model driven by pc_en.
module tb_ifetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_addr;
  logic        pc_en;
  logic        redirect;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_fault;

  logic [63:0] tgt;
  int          n_chk  = 0;
  int          n_bad  = 0;
  int          n_pcen = 0;

  always #5 clk = ~clk;

  ifetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_fault    (id_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: the PC model follows pc_en (redirect target or +4).
  task automatic tick();
    logic en;
    logic rd;
    en = pc_en;
    rd = redirect;
    @(posedge clk);
    #1;
    if (en) n_pcen++;
    if (reset)   pc_addr = 64'h0;
    else if (en) pc_addr = rd ? tgt : pc_addr + 64'd4;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_addr = 64'h0; redirect = 1'b0; tgt = 64'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_req",  64'(imem_req), 64'h0);
    chk("rst_pcen", 64'(pc_en),    64'h0);
    tick();
    #1;
    chk("rst_valid", 64'(id_valid), 64'h0);
    chk("rst_pc",    id_pc,         64'h0);
    chk("rst_instr", 64'(id_instr), 64'(NOP));
    chk("rst_fault", 64'(id_fault), 64'h0);
    tick();
    reset = 1'b0;
    n_pcen = 0;

    // basic fetch at 0x0
    #1;
    chk("first_req",  64'(imem_req), 64'h1);
    chk("first_addr", imem_addr,     64'h0);
    tick();
    imem_gnt = 1'b1;
    #1;
    chk("gnt_req", 64'(imem_req), 64'h1);
    tick();
    imem_gnt = 1'b0;
    #1;
    chk("wait_req",  64'(imem_req), 64'h0);
    chk("wait_pcen", 64'(pc_en),    64'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    #1;
    chk("rv_pcen", 64'(pc_en), 64'h1);
    tick();
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("ld_valid", 64'(id_valid), 64'h1);
    chk("ld_pc",    id_pc,         64'h0);
    chk("ld_instr", 64'(id_instr), 64'h0050_0093);
    chk("ld_fault", 64'(id_fault), 64'h0);
    chk("ld_npcen", 64'(n_pcen),   64'd1);
    chk("b2b_req",  64'(imem_req), 64'h1);
    chk("b2b_addr", imem_addr,     64'h4);
    tick();
    imem_gnt = 1'b0;

    // handshake clears; second word loads and then stalls
    #1;
    chk("hs_valid", 64'(id_valid), 64'h0);
    chk("hs_instr", 64'(id_instr), 64'(NOP));
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; id_ready = 1'b0;
    #1;
    chk("rv2_pcen", 64'(pc_en), 64'h1);
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stl_valid", 64'(id_valid), 64'h1);
      chk("stl_pc",    id_pc,         64'h4);
      chk("stl_instr", 64'(id_instr), 64'h00A0_0113);
      chk("stl_req",   64'(imem_req), 64'h0);
      chk("stl_pcen",  64'(pc_en),    64'h0);
      tick();
    end
    chk("stl_npcen", 64'(n_pcen), 64'd2);
    id_ready = 1'b1;
    #1;
    chk("rel_req",  64'(imem_req), 64'h1);
    chk("rel_addr", imem_addr,     64'h8);
    tick();
    #1;
    chk("rel_valid", 64'(id_valid), 64'h0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;

    // redirect while waiting; late response is dropped
    redirect = 1'b1; tgt = 64'h40;
    #1;
    chk("rd_pcen", 64'(pc_en),    64'h1);
    chk("rd_req",  64'(imem_req), 64'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("drp_req",  64'(imem_req), 64'h0);
    chk("drp_pcen", 64'(pc_en),    64'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drp_rv_pcen", 64'(pc_en),    64'h0);
    chk("drp_rv_req",  64'(imem_req), 64'h0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("drp_valid", 64'(id_valid), 64'h0);
    chk("drp_npcen", 64'(n_pcen),   64'd3);
    chk("drp_req2",  64'(imem_req), 64'h1);
    chk("drp_addr",  imem_addr,     64'h40);

    // redirect and response in the same cycle
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; tgt = 64'h100; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    chk("rdrv_pcen", 64'(pc_en), 64'h1);
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("rdrv_valid", 64'(id_valid), 64'h0);
    chk("rdrv_req",   64'(imem_req), 64'h1);
    chk("rdrv_addr",  imem_addr,     64'h100);

    // redirect to a misaligned PC
    redirect = 1'b1; tgt = 64'h6;
    #1;
    chk("rdi_req",  64'(imem_req), 64'h0);
    chk("rdi_pcen", 64'(pc_en),    64'h1);
    tick();
    redirect = 1'b0; id_ready = 1'b0;
    #1;
    chk("mis_req",  64'(imem_req), 64'h0);
    chk("mis_pcen", 64'(pc_en),    64'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("flt_valid", 64'(id_valid), 64'h1);
      chk("flt_fault", 64'(id_fault), 64'h1);
      chk("flt_pc",    id_pc,         64'h6);
      chk("flt_instr", 64'(id_instr), 64'(NOP));
      chk("flt_req",   64'(imem_req), 64'h0);
      chk("flt_pcen",  64'(pc_en),    64'h0);
      tick();
    end
    id_ready = 1'b1;
    #1;
    chk("flt_hs_req", 64'(imem_req), 64'h0);
    tick();
    #1;
    chk("flt_clr_valid", 64'(id_valid), 64'h0);
    chk("flt_clr_req",   64'(imem_req), 64'h0);
    redirect = 1'b1; tgt = 64'h200;
    #1;
    chk("flt_rd_pcen", 64'(pc_en), 64'h1);
    tick();
    redirect = 1'b0;
    #1;
    chk("post_flt_req",  64'(imem_req), 64'h1);
    chk("post_flt_addr", imem_addr,     64'h200);

    // reset while waiting; stray response afterwards is ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstw_req", 64'(imem_req), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("str_req",  64'(imem_req), 64'h1);
    chk("str_addr", imem_addr,     64'h0);
    chk("str_pcen", 64'(pc_en),    64'h0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("str_valid", 64'(id_valid), 64'h0);
    chk("str_instr", 64'(id_instr), 64'(NOP));
    chk("str_req2",  64'(imem_req), 64'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
